// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request on an SRAM-like bus, a registered
// decode slot with valid/ready, a one-entry overflow buffer; optional INST_FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        fetchStall,
    output logic        instReq,
    output logic [31:0] instAddr,
    input  logic        instAddrOk,
    input  logic        instDataOk,
    input  logic [31:0] instRdata,
    output logic        idValid,
    input  logic        idReady,
    output logic [31:0] idPc,
    output logic [31:0] idInstr,
    output logic        idAdel
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_instr_q;
    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;
    logic        id_adel_q;

    logic        slot_free;
    logic        misaligned;
    logic        load;
    logic [31:0] load_instr;
    logic        load_adel;
    logic        buf_load;

    assign slot_free = !id_valid_q || idReady;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // NOTE: every output of this block is given a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        instReq    = 1'b0;
        load       = 1'b0;
        load_instr = instRdata;
        load_adel  = 1'b0;
        buf_load   = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (misaligned) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (slot_free) begin
                        load       = 1'b1;
                        load_instr = NOP_INSTR;
                        load_adel  = 1'b1;
                    end
                end else begin
                    instReq = 1'b1;
                    if (instAddrOk) begin
                        state_d = flush ? DROP : RESP;
                    end else if (flush) begin
                        // withdraw for one cycle so the next request carries the redirected pc
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (flush) begin
                    state_d = instDataOk ? REQ : DROP;
                end else if (instDataOk) begin
                    if (slot_free) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = REQ;
                end else if (idReady) begin
                    load       = 1'b1;
                    load_instr = buf_instr_q;
                    state_d    = REQ;
                end
            end
            DROP: if (instDataOk) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    assign fetchStall = !load;
    assign instAddr   = pc;

    // NOTE: state is updated with non-blocking assignments, and reset is synchronous:
    // rst is only sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_instr_q <= NOP_INSTR;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'h0;
            id_instr_q  <= NOP_INSTR;
            id_adel_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (flush) begin
                buf_instr_q <= NOP_INSTR;
            end else if (buf_load) begin
                buf_instr_q <= instRdata;
            end

            // flush wins over a same-cycle load; a load wins over a plain consume
            if (flush) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
                id_adel_q  <= 1'b0;
            end else if (load) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= pc;
                id_instr_q <= load_instr;
                id_adel_q  <= load_adel;
            end else if (id_valid_q && idReady) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
                id_adel_q  <= 1'b0;
            end
        end
    end

    assign idValid = id_valid_q;
    assign idPc    = id_pc_q;
    assign idInstr = id_instr_q;
    assign idAdel  = id_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: reset, zero-wait fetch, HOLD back-pressure,
// flush in RESP and REQ, reset mid-transaction, and the misaligned-pc path.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        fetchStall;
    logic        instReq;
    logic [31:0] instAddr;
    logic        instAddrOk;
    logic        instDataOk;
    logic [31:0] instRdata;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [31:0] idInstr;
    logic        idAdel;

    int n_checks = 0;
    int n_fails  = 0;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .flush      (flush),
        .fetchStall (fetchStall),
        .instReq    (instReq),
        .instAddr   (instAddr),
        .instAddrOk (instAddrOk),
        .instDataOk (instDataOk),
        .instRdata  (instRdata),
        .idValid    (idValid),
        .idReady    (idReady),
        .idPc       (idPc),
        .idInstr    (idInstr),
        .idAdel     (idAdel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset
        rst = 1'b0; pc = 32'hBFC0_0000; flush = 1'b0;
        instAddrOk = 1'b1; instDataOk = 1'b1; instRdata = 32'h1111_1111; idReady = 1'b1;
        tick(); tick();
        check("rst_idValid",    {31'h0, idValid},    32'h0);
        check("rst_idPc",       idPc,                32'h0);
        check("rst_idInstr",    idInstr,             32'h0);
        check("rst_idAdel",     {31'h0, idAdel},     32'h0);
        check("rst_instReq",    {31'h0, instReq},    32'h0);
        check("rst_instAddr",   instAddr,            32'hBFC0_0000);
        check("rst_fetchStall", {31'h0, fetchStall}, 32'h1);

        // first fetch, zero-wait bus
        rst = 1'b1; #1;
        check("idle_instReq", {31'h0, instReq}, 32'h0);
        tick();
        check("req_instReq",    {31'h0, instReq},    32'h1);
        check("req_instAddr",   instAddr,            32'hBFC0_0000);
        check("req_fetchStall", {31'h0, fetchStall}, 32'h1);
        tick();
        idReady = 1'b0; #1;
        check("resp_fetchStall", {31'h0, fetchStall}, 32'h0);
        check("resp_idValid",    {31'h0, idValid},    32'h0);
        tick();
        check("w0_idValid", {31'h0, idValid}, 32'h1);
        check("w0_idPc",    idPc,             32'hBFC0_0000);
        check("w0_idInstr", idInstr,          32'h1111_1111);
        check("w0_idAdel",  {31'h0, idAdel},  32'h0);

        // back-pressure: second word parks in HOLD
        pc = 32'hBFC0_0004; instRdata = 32'h2222_2222; #1;
        check("w1_instReq",  {31'h0, instReq}, 32'h1);
        check("w1_instAddr", instAddr,         32'hBFC0_0004);
        tick();
        check("w1_resp_stall", {31'h0, fetchStall}, 32'h1);
        tick();
        check("hold_instReq", {31'h0, instReq},    32'h0);
        check("hold_stall",   {31'h0, fetchStall}, 32'h1);
        check("hold_idInstr", idInstr,             32'h1111_1111);
        tick();
        check("hold2_stall", {31'h0, fetchStall}, 32'h1);
        idReady = 1'b1; #1;
        check("hold_rdy_stall", {31'h0, fetchStall}, 32'h0);
        tick();
        check("w1_idValid", {31'h0, idValid}, 32'h1);
        check("w1_idPc",    idPc,             32'hBFC0_0004);
        check("w1_idInstr", idInstr,          32'h2222_2222);

        // flush in RESP with data delayed 3 cycles
        pc = 32'hBFC0_0008; instDataOk = 1'b0; instRdata = 32'h3333_3333; #1;
        check("f_req_instAddr", instAddr, 32'hBFC0_0008);
        tick();
        check("consume_idValid", {31'h0, idValid}, 32'h0);
        check("consume_idInstr", idInstr,          32'h0);
        flush = 1'b1; #1;
        check("f_resp_instReq", {31'h0, instReq}, 32'h0);
        tick();
        flush = 1'b0; pc = 32'hBFC0_0380; #1;
        check("drop_idValid", {31'h0, idValid}, 32'h0);
        tick(); tick();
        instDataOk = 1'b1; #1;
        check("drop_instReq", {31'h0, instReq}, 32'h0);
        tick();
        check("redir_instReq",  {31'h0, instReq}, 32'h1);
        check("redir_instAddr", instAddr,         32'hBFC0_0380);
        check("redir_idValid",  {31'h0, idValid}, 32'h0);
        instRdata = 32'h4444_4444;
        tick(); tick();
        check("w2_idPc",    idPc,    32'hBFC0_0380);
        check("w2_idInstr", idInstr, 32'h4444_4444);

        // flush in REQ before the address is accepted
        pc = 32'hBFC0_0384; instAddrOk = 1'b0; flush = 1'b1; #1;
        check("freq_instReq", {31'h0, instReq}, 32'h1);
        tick();
        flush = 1'b0; pc = 32'hBFC0_0500; instAddrOk = 1'b1; #1;
        check("freq_gap_instReq", {31'h0, instReq}, 32'h0);
        check("freq_idValid",     {31'h0, idValid}, 32'h0);
        tick();
        check("freq_reissue",  {31'h0, instReq}, 32'h1);
        check("freq_instAddr", instAddr,         32'hBFC0_0500);
        instRdata = 32'h5555_5555;
        tick(); tick();
        check("w3_idPc",    idPc,    32'hBFC0_0500);
        check("w3_idInstr", idInstr, 32'h5555_5555);

        // reset in RESP, late data after release
        pc = 32'hBFC0_0504; instDataOk = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; instDataOk = 1'b1; instRdata = 32'h6666_6666; #1;
        check("rr_idValid", {31'h0, idValid}, 32'h0);
        check("rr_instReq", {31'h0, instReq}, 32'h0);
        tick();
        check("rr2_idValid",  {31'h0, idValid}, 32'h0);
        check("rr2_instReq",  {31'h0, instReq}, 32'h1);
        check("rr2_instAddr", instAddr,         32'hBFC0_0504);
        instRdata = 32'h7777_7777;
        tick(); tick();
        check("w4_idPc",    idPc,    32'hBFC0_0504);
        check("w4_idInstr", idInstr, 32'h7777_7777);

        // misaligned pc
        pc = 32'hBFC0_0002; idReady = 1'b1;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        #1;
        check("mis_instReq", {31'h0, instReq},    32'h0);
        check("mis_stall",   {31'h0, fetchStall}, 32'h0);
        tick();
        check("mis_idValid", {31'h0, idValid}, 32'h1);
        check("mis_idPc",    idPc,             32'hBFC0_0002);
        check("mis_idInstr", idInstr,          32'h0);
        check("mis_idAdel",  {31'h0, idAdel},  32'h1);
`else
        #1;
        check("mis_instReq",  {31'h0, instReq}, 32'h1);
        check("mis_instAddr", instAddr,         32'hBFC0_0002);
        instRdata = 32'h8888_8888;
        tick(); tick();
        check("mis_idPc",    idPc,            32'hBFC0_0002);
        check("mis_idInstr", idInstr,         32'h8888_8888);
        check("mis_idAdel",  {31'h0, idAdel}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly downstream of the PC register. It takes the current `pc`, issues one request at a time on the SRAM-like instruction bus, and captures the returned word. It presents `{pc, instr}` to decode through a valid/ready handshake. It holds the PC via `fetchStall` until the fetched word has a place to go, and discards in-flight fetches when control redirects the PC.

## Interface
- `NOP_INSTR`, default `32'h0000_0000`: value driven on `idInstr` when no valid instruction or after reset.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-low reset; `rst == 0` at a posedge resets the block.
- `pc`  in  32  current PC from the PC register.
- `flush`  in  1  redirect pulse (exception/eret/branch/jump taken); the PC register redirects regardless of `fetchStall`.
- `fetchStall`  out  1  when high, the PC register must not advance sequentially.
- `instReq`  out  1  bus request valid.
- `instAddr`  out  32  bus request address; equals `pc` while `instReq` is high.
- `instAddrOk`  in  1  request accepted this cycle.
- `instDataOk`  in  1  read data valid this cycle.
- `instRdata`  in  32  read data.
- `idValid`  out  1  decode slot holds a valid instruction.
- `idReady`  in  1  decode accepts the slot this cycle.
- `idPc`  out  32  PC of the slot instruction.
- `idInstr`  out  32  instruction word.
- `idAdel`  out  1  address-error (fetch) flag for the slot.

## Operation
- FSM states:
  - IDLE: entered on reset. Moves to REQ next cycle.
  - REQ: drives `instReq=1` with `instAddr=pc`. On `instAddrOk`, moves to RESP. If `flush` is high and `instAddrOk` is low, drops `instReq` and restarts REQ next cycle with the new `pc`.
  - RESP: waits for `instDataOk`. Then:
    - if the slot is free (`!idValid || idReady`), loads the slot with `{pc, instRdata}` and returns to REQ;
    - otherwise, captures the word into a one-entry buffer and moves to HOLD.
  - HOLD: when `idReady` is high, moves the buffer into the slot and goes to REQ.
  - DROP: entered when `flush` arrives in RESP, or in REQ in the same cycle as `instAddrOk`. Waits for `instDataOk`, discards the data, then goes to REQ.
- `fetchStall` is 0 only in the cycle a word enters the slot (RESP with a free slot, or HOLD with `idReady`). It is 1 in all other cycles, so `pc` is stable in REQ/RESP.
- Slot handshake:
  - `idValid && idReady` consumes the slot.
  - A slot load in the same cycle as consumption leaves `idValid=1` with the new contents.
  - Otherwise consumption clears `idValid`, and `idInstr` goes to `NOP_INSTR`.
- `flush`:
  - clears `idValid` and the HOLD buffer;
  - HOLD goes to REQ;
  - takes priority over any same-cycle slot load.
- Bus rules:
  - at most one outstanding request;
  - `instReq` never high in RESP/DROP/HOLD;
  - request withdrawal allowed only before `instAddrOk`.

## Timing
- Reset values:
  - `idValid=0`, `idPc=0`, `idInstr=NOP_INSTR`, `idAdel=0`;
  - `instReq=0`, `instAddr=pc`, `fetchStall=1`;
  - state IDLE, buffer empty.
- Zero-wait bus (`addrOk` in REQ, `dataOk` the next cycle): one instruction every 2 cycles; `idValid` rises 2 cycles after entering REQ.
- Slot outputs are registered. `fetchStall` and `instReq` are combinational from state and inputs.
- Reset asserted mid-transaction returns to IDLE. Any late `instDataOk` that arrives after reset is ignored, because the next request is issued only from REQ, after reset.

## Configuration
- `INST_FETCH_ALIGN_CHECK_EN` defined:
  - in REQ with `pc[1:0] != 0`, no bus request is issued;
  - the slot is loaded (under the same free-slot rule) with `idPc=pc`, `idInstr=NOP_INSTR`, `idAdel=1`;
  - `fetchStall` drops that cycle.
- Not defined: `idAdel` is tied to 0, and misaligned PCs are fetched as-is.

## Test plan
- Reset with `rst=0` for 2 cycles, `pc=32'hBFC0_0000`, zero-wait bus -> all reset values hold; after release, `instReq=1`, `instAddr=BFC0_0000`; 2 cycles later `idValid=1`, `idPc=BFC0_0000`, `idInstr=instRdata`, with `fetchStall=0` in the load cycle.
- `idReady=0` for 5 cycles while 2 fetches complete -> the second word waits in HOLD, `fetchStall=1` and no `instReq`; on `idReady=1` the slot advances in order with no lost word.
- `flush` in RESP with `dataOk` delayed 3 cycles -> DROP discards the data, `idValid=0`, and the next `instAddr` equals the redirected `pc` (e.g. `BFC0_0380`).
- `flush` in REQ with `instAddrOk=0` -> `instReq` drops for 1 cycle and reissues with the new `pc`; no data is consumed.
- `rst` pulled low in RESP, then `instDataOk` arrives after release -> data is ignored, the slot stays invalid, and the fetch restarts at the current `pc`.
- With `INST_FETCH_ALIGN_CHECK_EN`, `pc=32'hBFC0_0002` -> no `instReq`; slot gets `idAdel=1`, `idInstr=0`, `idPc=BFC0_0002`.
